// File: rtl/bpm_pkg.sv
// Shared constants, FSM state type and saturation helper for the BPM calculator.
package bpm_pkg;
   localparam int SAMPLE_RATE_HZ = 25;
   localparam int K              = 60 * SAMPLE_RATE_HZ;
   localparam int CNT_W          = 6;
   localparam int BPM_W          = 8;
   localparam int NUM_W          = 11;
   localparam int MIN_INTERVAL   = 6;
   localparam int AVG_DEPTH      = 4;
   localparam int AVG_SHIFT      = 2;
   localparam int PTR_W          = 2;
   localparam int FILL_W         = 3;
   localparam int SUM_W          = BPM_W + AVG_SHIFT;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_DIVIDE  = 2'd1,
      S_AVERAGE = 2'd2,
      S_DONE    = 2'd3
   } state_t;

   function automatic logic [BPM_W-1:0] sat_bpm(input logic [NUM_W-1:0] q);
      if (q > NUM_W'((1 << BPM_W) - 1)) return '1;
      return q[BPM_W-1:0];
   endfunction
endpackage

// File: rtl/bpm_seq_divider.sv
// Restoring divider, one quotient bit per clock MSB first; o_done is high in the
// cycle whose closing edge computes the last bit, i.e. the NUM_W-th edge after start.
module bpm_seq_divider #(
   parameter int NUM_W = 11,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_start,
   input  logic [NUM_W-1:0] i_dividend,
   input  logic [CNT_W-1:0] i_divisor,
   output logic             o_busy,
   output logic             o_done,
   output logic [NUM_W-1:0] o_quotient
);
   localparam int IDX_W = $clog2(NUM_W);

   logic             r_busy;
   logic [IDX_W-1:0] r_idx;
   logic [NUM_W-1:0] r_dvd;
   logic [CNT_W-1:0] r_dvs;
   logic [CNT_W-1:0] r_rem;
   logic [NUM_W-1:0] r_quo;

   logic [CNT_W:0]   w_trial;
   logic [CNT_W:0]   w_diff;
   logic             w_ge;
   logic [CNT_W-1:0] w_rem_next;

   // Remainder stays below the divisor, so trial < 2*divisor fits in CNT_W+1 bits.
   assign w_trial    = {r_rem, r_dvd[NUM_W-1]};
   assign w_diff     = w_trial - {1'b0, r_dvs};
   assign w_ge       = (w_trial >= {1'b0, r_dvs});
   assign w_rem_next = w_ge ? w_diff[CNT_W-1:0] : w_trial[CNT_W-1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_busy <= 1'b0;
         r_idx  <= '0;
         r_dvd  <= '0;
         r_dvs  <= '0;
         r_rem  <= '0;
         r_quo  <= '0;
      end else if (i_start) begin
         r_busy <= 1'b1;
         r_idx  <= IDX_W'(NUM_W - 1);
         r_dvd  <= i_dividend;
         r_dvs  <= i_divisor;
         r_rem  <= '0;
         r_quo  <= '0;
      end else if (r_busy) begin
         r_rem <= w_rem_next;
         r_dvd <= {r_dvd[NUM_W-2:0], 1'b0};
         r_quo <= {r_quo[NUM_W-2:0], w_ge};
         if (r_idx == '0) r_busy <= 1'b0;
         else             r_idx  <= r_idx - 1'b1;
      end
   end

   assign o_busy     = r_busy;
   assign o_done     = r_busy && (r_idx == '0);
   assign o_quotient = r_quo;
endmodule

// File: rtl/bpm_calculator.sv
// Converts an inter-beat interval in sample ticks to BPM and keeps a 4-beat average.
//   state     | meaning
//   S_IDLE    | wait for an accepted rising edge of valid
//   S_DIVIDE  | divider running K / N
//   S_AVERAGE | push quotient into history, update bpm_inst / bpm_out
//   S_DONE    | raise one-cycle done pulses, then back to idle
module bpm_calculator
   import bpm_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [CNT_W-1:0] time_counter,
   input  logic             valid,
   output logic             BPMCalc_Done,
   output logic [BPM_W-1:0] bpm_inst,
   output logic [BPM_W-1:0] bpm_out,
   output logic             bpm_valid,
   output logic             interval_err
);
   state_t            r_state;
   logic              r_valid_d;
   logic              r_err;
   logic [BPM_W-1:0]  r_hist [AVG_DEPTH];
   logic [PTR_W-1:0]  r_ptr;
   logic [FILL_W-1:0] r_fill;
   logic [BPM_W-1:0]  r_bpm_inst;
   logic [BPM_W-1:0]  r_bpm_out;
   logic              r_done_p;
   logic              r_valid_p;
   logic              r_err_p;

   logic              w_accept;
   logic              w_short;
   logic              w_start;
   logic              w_div_busy;
   logic              w_div_done;
   logic [NUM_W-1:0]  w_quotient;
   logic [BPM_W-1:0]  w_q_sat;
   logic [SUM_W-1:0]  w_sum;
   logic [FILL_W-1:0] w_new_fill;

   // Edge-triggered on valid so the counter's held-high valid cannot retrigger.
   assign w_accept = valid && !r_valid_d && en && (r_state == S_IDLE) && !w_div_busy;
   assign w_short  = (time_counter < CNT_W'(MIN_INTERVAL));
   assign w_start  = w_accept && !w_short;
   assign w_q_sat  = sat_bpm(w_quotient);

   bpm_seq_divider #(.NUM_W(NUM_W), .CNT_W(CNT_W)) u_div (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_start    (w_start),
      .i_dividend (NUM_W'(K)),
      .i_divisor  (time_counter),
      .o_busy     (w_div_busy),
      .o_done     (w_div_done),
      .o_quotient (w_quotient)
   );

   // Sum of the history as it will look after this push.
   always_comb begin
      w_sum = '0;
      for (int i = 0; i < AVG_DEPTH; i++) begin
         if (PTR_W'(i) == r_ptr) w_sum = w_sum + SUM_W'(w_q_sat);
         else                    w_sum = w_sum + SUM_W'(r_hist[i]);
      end
   end

   assign w_new_fill = (r_fill < FILL_W'(AVG_DEPTH)) ? r_fill + 1'b1 : r_fill;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_valid_d  <= 1'b0;
         r_err      <= 1'b0;
         r_ptr      <= '0;
         r_fill     <= '0;
         r_bpm_inst <= '0;
         r_bpm_out  <= '0;
         r_done_p   <= 1'b0;
         r_valid_p  <= 1'b0;
         r_err_p    <= 1'b0;
         for (int i = 0; i < AVG_DEPTH; i++) r_hist[i] <= '0;
      end else begin
         r_valid_d <= valid;
         r_done_p  <= 1'b0;
         r_valid_p <= 1'b0;
         r_err_p   <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_err   <= w_short;
                  r_state <= w_short ? S_DONE : S_DIVIDE;
               end
            end
            S_DIVIDE: begin
               if (w_div_done) r_state <= S_AVERAGE;
            end
            S_AVERAGE: begin
               r_hist[r_ptr] <= w_q_sat;
               r_ptr         <= r_ptr + 1'b1;
               r_fill        <= w_new_fill;
               r_bpm_inst    <= w_q_sat;
               r_bpm_out     <= (w_new_fill == FILL_W'(AVG_DEPTH)) ?
                                w_sum[SUM_W-1:AVG_SHIFT] : w_q_sat;
               r_state       <= S_DONE;
            end
            S_DONE: begin
               r_done_p  <= 1'b1;
               r_valid_p <= !r_err;
               r_err_p   <= r_err;
               r_state   <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign BPMCalc_Done = r_done_p;
   assign bpm_valid    = r_valid_p;
   assign interval_err = r_err_p;
   assign bpm_inst     = r_bpm_inst;
   assign bpm_out      = r_bpm_out;
endmodule

// File: tb/tb_bpm_calculator.sv
// Self-checking bench for bpm_calculator: vector table plus hand-written handshake/reset sequences.
module tb_bpm_calculator;
   logic       clk;
   logic       rst_n;
   logic       en;
   logic [5:0] time_counter;
   logic       valid;
   logic       BPMCalc_Done;
   logic [7:0] bpm_inst;
   logic [7:0] bpm_out;
   logic       bpm_valid;
   logic       interval_err;

   int checks = 0;
   int errors = 0;
   int n_done = 0;
   int exp_total = 0;

   typedef struct packed {
      logic [7:0] inst;
      logic [7:0] out;
      logic       err;
   } exp_t;

   typedef struct {
      bit rst;
      int n;
      bit en;
      bit exp_done;
      int exp_inst;
      int exp_out;
      bit exp_err;
      int exp_lat;
   } vec_t;

   exp_t sb[$];
   vec_t vecs[12];

   bpm_calculator dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .en           (en),
      .time_counter (time_counter),
      .valid        (valid),
      .BPMCalc_Done (BPMCalc_Done),
      .bpm_inst     (bpm_inst),
      .bpm_out      (bpm_out),
      .bpm_valid    (bpm_valid),
      .interval_err (interval_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   // Scoreboard: every done pulse pops one expected result.
   always @(posedge clk) begin
      #1;
      if (BPMCalc_Done) begin
         exp_t e;
         n_done++;
         if (sb.size() == 0) begin
            chk("unexpected_done", 1, 0);
         end else begin
            e = sb.pop_front();
            chk("bpm_inst", bpm_inst, e.inst);
            chk("bpm_out", bpm_out, e.out);
            chk("bpm_valid", bpm_valid, !e.err);
            chk("interval_err", interval_err, e.err);
         end
      end
   end

   task automatic do_reset();
      rst_n = 1'b0;
      valid = 1'b0;
      en = 1'b1;
      time_counter = '0;
      repeat (2) @(negedge clk);
      chk("rst_done", BPMCalc_Done, 0);
      chk("rst_inst", bpm_inst, 0);
      chk("rst_out", bpm_out, 0);
      chk("rst_valid", bpm_valid, 0);
      chk("rst_err", interval_err, 0);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic run_vec(input vec_t v);
      int k;
      bit got;
      @(negedge clk);
      time_counter = 6'(v.n);
      en = v.en;
      valid = 1'b1;
      if (v.exp_done) begin
         sb.push_back('{inst: 8'(v.exp_inst), out: 8'(v.exp_out), err: v.exp_err});
         exp_total++;
      end
      k = 0;
      got = 0;
      while (!got && k < 20) begin
         @(posedge clk);
         #1;
         k++;
         if (BPMCalc_Done) got = 1;
      end
      if (v.exp_done) chk("latency", got ? k - 1 : -1, v.exp_lat);
      else            chk("dropped_edge", int'(got), 0);
      // valid stays high past done: no retrigger, pulses one cycle wide
      repeat (3) begin
         @(posedge clk);
         #1;
         chk("done_width", BPMCalc_Done, 0);
         chk("valid_width", bpm_valid, 0);
         chk("err_width", interval_err, 0);
      end
      @(negedge clk);
      valid = 1'b0;
      en = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      bit got;
      //             rst  n  en done inst out err lat
      vecs[0]  = '{1, 25, 1, 1,  60,  60, 0, 13};
      vecs[1]  = '{0, 20, 1, 1,  75,  75, 0, 13};
      vecs[2]  = '{0,  5, 1, 1,  75,  75, 1,  1};
      vecs[3]  = '{0,  0, 1, 1,  75,  75, 1,  1};
      vecs[4]  = '{0, 25, 0, 0,   0,   0, 0,  0};
      vecs[5]  = '{0, 63, 1, 1,  23,  23, 0, 13};
      vecs[6]  = '{0,  6, 1, 1, 250, 102, 0, 13};
      vecs[7]  = '{1, 25, 1, 1,  60,  60, 0, 13};
      vecs[8]  = '{0, 25, 1, 1,  60,  60, 0, 13};
      vecs[9]  = '{0, 20, 1, 1,  75,  75, 0, 13};
      vecs[10] = '{0, 20, 1, 1,  75,  67, 0, 13};
      vecs[11] = '{0, 25, 1, 1,  60,  67, 0, 13};

      rst_n = 1'b0;
      en = 1'b1;
      valid = 1'b0;
      time_counter = '0;

      for (int i = 0; i < 12; i++) begin
         if (vecs[i].rst) do_reset();
         run_vec(vecs[i]);
      end

      // valid dropped and re-raised mid-DIVIDE with an illegal N must be ignored
      @(negedge clk);
      time_counter = 6'd20;
      en = 1'b1;
      valid = 1'b1;
      sb.push_back('{inst: 8'd75, out: 8'd71, err: 1'b0});
      exp_total++;
      repeat (4) @(negedge clk);
      valid = 1'b0;
      @(negedge clk);
      time_counter = 6'd5;
      valid = 1'b1;
      k = 0;
      got = 0;
      while (!got && k < 20) begin
         @(posedge clk);
         #1;
         k++;
         if (BPMCalc_Done) got = 1;
      end
      chk("toggle_done", int'(got), 1);
      repeat (3) begin
         @(posedge clk);
         #1;
         chk("toggle_no_retrigger", BPMCalc_Done, 0);
      end
      @(negedge clk);
      valid = 1'b0;
      repeat (2) @(negedge clk);

      // reset after edge E5 of a computation: outputs clear, no done pulse
      @(negedge clk);
      time_counter = 6'd25;
      valid = 1'b1;
      repeat (6) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      valid = 1'b0;
      #1;
      chk("midrst_inst", bpm_inst, 0);
      chk("midrst_out", bpm_out, 0);
      chk("midrst_done", BPMCalc_Done, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      chk("midrst_no_done", n_done, exp_total);
      run_vec('{0, 25, 1, 1, 60, 60, 0, 13});
      run_vec('{0, 6, 1, 1, 250, 250, 0, 13});

      chk("done_count", n_done, exp_total);
      chk("sb_empty", sb.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
